// File: rtl/xmtr.sv
`default_nettype none
// ============================================================================
// Module      : xmtr
// Description : Serial framer; sends {MATCH, data} MSB first, one bit per clock,
//               with a one-byte holding register and a sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module xmtr #(
    parameter logic [7:0] MATCH = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data_in,
    output logic       ready,
    output logic       overrun,
    output logic       sending,
    output logic       serial_out
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      state_q,     state_d;
    logic [7:0]  hold_data_q, hold_data_d;
    logic        hold_full_q, hold_full_d;
    logic        ready_q,     ready_d;
    logic        overrun_q,   overrun_d;
    logic        sending_q,   sending_d;
    logic        serial_q,    serial_d;
    logic [15:0] shift_q,     shift_d;
    logic [3:0]  count_q,     count_d;

    logic w_accept;
    logic w_last_bit;
    logic w_start;

    // Acceptance uses the pre-edge hold state, so a load colliding with a
    // transfer out of the holding register is rejected.
    assign w_accept   = load && !hold_full_q;
    assign w_last_bit = (state_q == SEND) && (count_q == 4'd15);
    assign w_start    = hold_full_q && ((state_q == IDLE) || w_last_bit);

    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        overrun_d   = overrun_q;
        sending_d   = sending_q;
        serial_d    = serial_q;
        shift_d     = shift_q;
        count_d     = count_q;

        if (w_accept) begin
            hold_data_d = data_in;
            hold_full_d = 1'b1;
            overrun_d   = 1'b0;
        end else if (load) begin
            overrun_d   = 1'b1;
        end

        if (w_start) begin
            shift_d     = {MATCH, hold_data_q};
            hold_full_d = 1'b0;
            count_d     = 4'd0;
            state_d     = SEND;
            serial_d    = MATCH[7];
            sending_d   = 1'b1;
        end else if (w_last_bit) begin
            state_d     = IDLE;
            serial_d    = 1'b0;
            sending_d   = 1'b0;
        end else if (state_q == SEND) begin
            shift_d     = {shift_q[14:0], 1'b0};
            serial_d    = shift_q[14];
            count_d     = count_q + 4'd1;
        end

        ready_d = !hold_full_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b1;
            overrun_q   <= 1'b0;
            sending_q   <= 1'b0;
            serial_q    <= 1'b0;
            count_q     <= 4'd0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ready_d;
            overrun_q   <= overrun_d;
            sending_q   <= sending_d;
            serial_q    <= serial_d;
            count_q     <= count_d;
        end
    end

    // Data path registers carry no reset; their contents are qualified by state.
    always_ff @(posedge clock) begin
        hold_data_q <= hold_data_d;
        shift_q     <= shift_d;
    end

    assign ready      = ready_q;
    assign overrun    = overrun_q;
    assign sending    = sending_q;
    assign serial_out = serial_q;

endmodule
`default_nettype wire

// File: tb/tb_xmtr.sv
`default_nettype none
// ============================================================================
// Module      : tb_xmtr
// Description : Directed self-checking bench for xmtr, with a behavioural
//               frame decoder standing in for the receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xmtr;

    logic       clock = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] data_in;
    wire        ready;
    wire        overrun;
    wire        sending;
    wire        serial_out;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    xmtr #(.MATCH(8'hA5)) dut (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .data_in   (data_in),
        .ready     (ready),
        .overrun   (overrun),
        .sending   (sending),
        .serial_out(serial_out)
    );

    // Receiver model: hunt for the header byte, then take the next 8 bits.
    logic       dec_hunt = 1'b1;
    logic [7:0] dec_win  = 8'h00;
    logic [3:0] dec_cnt  = 4'd0;
    logic [7:0] rxq[$];

    always @(negedge clock) begin
        if (reset) begin
            dec_hunt <= 1'b1;
            dec_win  <= 8'h00;
            dec_cnt  <= 4'd0;
        end else if (dec_hunt) begin
            dec_win <= {dec_win[6:0], serial_out};
            if ({dec_win[6:0], serial_out} == 8'hA5) begin
                dec_hunt <= 1'b0;
                dec_cnt  <= 4'd0;
                dec_win  <= 8'h00;
            end
        end else begin
            dec_win <= {dec_win[6:0], serial_out};
            dec_cnt <= dec_cnt + 4'd1;
            if (dec_cnt == 4'd7) begin
                rxq.push_back({dec_win[6:0], serial_out});
                dec_hunt <= 1'b1;
                dec_win  <= 8'h00;
            end
        end
    end

    task automatic do_load(input logic [7:0] d);
        load    = 1'b1;
        data_in = d;
        @(posedge clock); #1;
        load    = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        load  = 1'b0;
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (ready !== 1'b1)      begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        checks++; if (overrun !== 1'b0)    begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        checks++; if (sending !== 1'b0)    begin errors++; $display("FAIL reset_sending: got %b want 0", sending); end
        checks++; if (serial_out !== 1'b0) begin errors++; $display("FAIL reset_serial: got %b want 0", serial_out); end
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_single_byte();
        logic [15:0] bits = '0;
        int scnt = 0;
        do_load(8'h3C);
        checks++; if (ready !== 1'b0)      begin errors++; $display("FAIL single_ready_k: got %b want 0", ready); end
        checks++; if (serial_out !== 1'b0) begin errors++; $display("FAIL single_serial_k: got %b want 0", serial_out); end
        for (int i = 0; i < 16; i++) begin
            @(posedge clock); #1;
            bits = {bits[14:0], serial_out};
            if (sending === 1'b1) scnt++;
            if (i == 0) begin
                checks++; if (ready !== 1'b1) begin errors++; $display("FAIL single_ready_k1: got %b want 1", ready); end
            end
        end
        checks++; if (bits !== 16'hA53C) begin errors++; $display("FAIL single_frame: got %h want a53c", bits); end
        checks++; if (scnt != 16)        begin errors++; $display("FAIL single_sending_len: got %0d want 16", scnt); end
        @(posedge clock); #1;
        checks++; if ({serial_out, sending} !== 2'b00) begin errors++; $display("FAIL single_tail: got %b want 00", {serial_out, sending}); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] bits = '0;
        int scnt = 0;
        do_load(8'hFF);
        for (int i = 0; i < 32; i++) begin
            @(posedge clock); #1;
            bits = {bits[30:0], serial_out};
            if (sending === 1'b1) scnt++;
            if (i == 0) begin
                load = 1'b1; data_in = 8'h00;
            end else begin
                load = 1'b0;
            end
        end
        checks++; if (bits !== 32'hA5FFA500) begin errors++; $display("FAIL b2b_frames: got %h want a5ffa500", bits); end
        checks++; if (scnt != 32)            begin errors++; $display("FAIL b2b_sending_len: got %0d want 32", scnt); end
        @(posedge clock); #1;
        checks++; if ({serial_out, sending, ready} !== 3'b001) begin errors++; $display("FAIL b2b_tail: got %b want 001", {serial_out, sending, ready}); end
    endtask

    task automatic test_overrun();
        logic [31:0] bits  = '0;
        logic [15:0] bits2 = '0;
        do_load(8'h11);
        for (int i = 0; i < 32; i++) begin
            @(posedge clock); #1;
            bits = {bits[30:0], serial_out};
            if (i == 0) begin
                load = 1'b1; data_in = 8'h22;
            end else if (i == 1) begin
                checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ovr_ready_full: got %b want 0", ready); end
                load = 1'b1; data_in = 8'h33;
            end else begin
                load = 1'b0;
                if (i == 2) begin
                    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
                end
            end
        end
        checks++; if (bits !== 32'hA511A522) begin errors++; $display("FAIL ovr_frames: got %h want a511a522", bits); end
        @(posedge clock); #1;
        checks++; if ({serial_out, sending} !== 2'b00) begin errors++; $display("FAIL ovr_no_33: got %b want 00", {serial_out, sending}); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
        do_load(8'h44);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", overrun); end
        for (int i = 0; i < 16; i++) begin
            @(posedge clock); #1;
            bits2 = {bits2[14:0], serial_out};
        end
        checks++; if (bits2 !== 16'hA544) begin errors++; $display("FAIL ovr_frame44: got %h want a544", bits2); end
        @(posedge clock); #1;
    endtask

    task automatic test_collision();
        logic [15:0] bits = '0;
        do_load(8'hAA);
        load = 1'b1; data_in = 8'hBB;
        for (int i = 0; i < 16; i++) begin
            @(posedge clock); #1;
            bits = {bits[14:0], serial_out};
            if (i == 0) begin
                checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL coll_overrun: got %b want 1", overrun); end
                checks++; if (ready !== 1'b1)   begin errors++; $display("FAIL coll_ready: got %b want 1", ready); end
                load = 1'b0;
            end
        end
        checks++; if (bits !== 16'hA5AA) begin errors++; $display("FAIL coll_frame: got %h want a5aa", bits); end
        @(posedge clock); #1;
        checks++; if ({serial_out, sending} !== 2'b00) begin errors++; $display("FAIL coll_no_bb: got %b want 00", {serial_out, sending}); end
    endtask

    task automatic test_async_reset();
        int bad = 0;
        apply_reset();
        do_load(8'h3C);
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            if (i == 0)      begin load = 1'b1; data_in = 8'h77; end
            else if (i == 1) begin load = 1'b1; data_in = 8'h88; end
            else             load = 1'b0;
        end
        checks++; if ({sending, overrun} !== 2'b11) begin errors++; $display("FAIL areset_pre: got %b want 11", {sending, overrun}); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({serial_out, sending, overrun, ready} !== 4'b0001) begin
            errors++; $display("FAIL areset_immediate: got %b want 0001", {serial_out, sending, overrun, ready});
        end
        @(posedge clock);
        #3 reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (serial_out !== 1'b0 || sending !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL areset_no_resume: got %0d active cycles want 0", bad); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL areset_ready: got %b want 1", ready); end
    endtask

    task automatic test_idle();
        int bad = 0;
        apply_reset();
        for (int i = 0; i < 50; i++) begin
            @(posedge clock); #1;
            if (serial_out !== 1'b0 || sending !== 1'b0 || ready !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_quiet: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_first_edge();
        logic [15:0] bits = '0;
        reset = 1'b1;
        @(posedge clock);
        #3 reset = 1'b0;
        load = 1'b1; data_in = 8'hC3;
        @(posedge clock); #1;
        load = 1'b0;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL first_edge_accept: got %b want 0", ready); end
        for (int i = 0; i < 16; i++) begin
            @(posedge clock); #1;
            bits = {bits[14:0], serial_out};
        end
        checks++; if (bits !== 16'hA5C3) begin errors++; $display("FAIL first_edge_frame: got %h want a5c3", bits); end
        @(posedge clock); #1;
    endtask

    task automatic test_loopback();
        logic [7:0] lb [3] = '{8'h5A, 8'hA5, 8'h00};
        int n;
        apply_reset();
        rxq.delete();
        for (int b = 0; b < 3; b++) begin
            n = 0;
            while (ready !== 1'b1 && n < 40) begin
                @(posedge clock); #1;
                n++;
            end
            checks++; if (n >= 40) begin errors++; $display("FAIL loop_ready_timeout: got ready=%b want 1", ready); end
            do_load(lb[b]);
        end
        n = 0;
        while (rxq.size() < 3 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        checks++; if (rxq.size() != 3) begin errors++; $display("FAIL loop_count: got %0d bytes want 3", rxq.size()); end
        for (int b = 0; b < 3; b++) begin
            if (b < rxq.size()) begin
                checks++; if (rxq[b] !== lb[b]) begin errors++; $display("FAIL loop_byte%0d: got %h want %h", b, rxq[b], lb[b]); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        load    = 1'b0;
        data_in = 8'h00;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overrun();
        test_collision();
        test_async_reset();
        test_idle();
        test_first_edge();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
